// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Load/store bus between the datapath (master) and the data-memory
// responder (slave).
//   req_valid/req_ready : request handshake (master -> slave)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata, req_be   : store data and byte enables (bit i -> byte i)
//   rsp_valid/rsp_ready : response handshake (slave -> master)
//   rsp_rdata, rsp_err  : load data (0 for stores/errors) and error flag
//   access_count        : completed responses, wraps modulo 2^16
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] access_count;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, access_count
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, access_count
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side target for the datapath's load/store port. Accepts one request
// at a time, waits WAIT_STATES cycles, then performs the access on an
// internal word array and presents a response until it is accepted.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : dmem_responder_if.slave (request/response handshakes, data,
//           error flag and completed-access counter)
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, 4..4096)
//   WAIT_STATES : extra cycles between acceptance and response (0..15)
//   BASE_ADDR   : byte address of word 0 (word-aligned)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;
    logic        rsp_load_reg;     // response carries load data
    logic [15:0] access_count_reg;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic [31:0] acc_offset;
    logic [IDX_W-1:0] acc_idx;
    logic        acc_err;
    logic        start_now;
    logic        acc_now;
    logic        mem_we;
    logic [31:0] rd_word;

    // With zero wait states the access happens on the handshake edge itself,
    // so the request fields come straight from the bus; otherwise they come
    // from the copy captured at the handshake.
    always_comb begin
        acc_we    = we_reg;
        acc_addr  = addr_reg;
        acc_wdata = wdata_reg;
        acc_be    = be_reg;
        if (state_reg == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end
    end

    // BASE_ADDR is word-aligned, so offset[1:0] equals addr[1:0].
    assign acc_offset = acc_addr - BASE_ADDR;
    assign acc_idx    = acc_offset[IDX_W+1:2];
    assign acc_err    = (acc_offset[1:0] != 2'b00) ||
                        ({2'b00, acc_offset[31:2]} >= DEPTH_WORDS);

    assign start_now = (state_reg == IDLE) && bus.req_valid;
    assign acc_now   = (start_now && (WAIT_STATES == 0)) ||
                       ((state_reg == WAIT) && (cnt_reg == 4'd0));
    // Reset gating keeps a store from committing on the very edge reset rises.
    assign mem_we    = acc_now && acc_we && !acc_err && !reset;

    // One byte-wide array per lane so each lane maps onto a plain RAM with
    // its own write enable; read data is registered on the access edge.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [0:DEPTH_WORDS-1];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clock) begin
                if (mem_we && acc_be[gi]) begin
                    mem_lane[acc_idx] <= acc_wdata[8*gi +: 8];
                end
                if (acc_now) begin
                    rd_byte_reg <= mem_lane[acc_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            we_reg           <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            be_reg           <= '0;
            req_ready_reg    <= 1'b1;
            rsp_valid_reg    <= 1'b0;
            rsp_err_reg      <= 1'b0;
            rsp_load_reg     <= 1'b0;
            access_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_reg        <= bus.req_we;
                        addr_reg      <= bus.req_addr;
                        wdata_reg     <= bus.req_wdata;
                        be_reg        <= bus.req_be;
                        req_ready_reg <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= acc_err;
                            rsp_load_reg  <= !acc_we && !acc_err;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= acc_err;
                        rsp_load_reg  <= !acc_we && !acc_err;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg        <= IDLE;
                        rsp_valid_reg    <= 1'b0;
                        req_ready_reg    <= 1'b1;
                        access_count_reg <= access_count_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_reg;
    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_err      = rsp_err_reg;
    assign bus.rsp_rdata    = rsp_load_reg ? rd_word : 32'h0;
    assign bus.access_count = access_count_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Three responder instances share one set of bench-side request signals;
// 'sel' routes valid/ready to one of them and picks its outputs:
//   sel 0 : DEPTH 64,  WAIT_STATES 2, base 0      (vector table + random)
//   sel 1 : DEPTH 256, WAIT_STATES 4, base 0      (reset during WAIT)
//   sel 2 : DEPTH 16,  WAIT_STATES 0, base 0x100  (back-to-back stream)
// ---------------------------------------------------------------------------
module tb_dmem_responder;
    localparam int          DEPTH2 = 64;
    localparam logic [31:0] BASE2  = 32'h0;

    logic clock;
    logic rst2, rst4, rst0;
    logic [1:0] sel;

    logic        t_req_valid, t_req_we, t_rsp_ready;
    logic [31:0] t_req_addr, t_req_wdata;
    logic [3:0]  t_req_be;

    logic        c_req_ready, c_rsp_valid, c_rsp_err;
    logic [31:0] c_rsp_rdata;
    logic [15:0] c_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    dmem_responder_if b2();
    dmem_responder_if b4();
    dmem_responder_if b0();

    assign b2.req_valid = t_req_valid && (sel == 2'd0);
    assign b4.req_valid = t_req_valid && (sel == 2'd1);
    assign b0.req_valid = t_req_valid && (sel == 2'd2);
    assign b2.rsp_ready = t_rsp_ready && (sel == 2'd0);
    assign b4.rsp_ready = t_rsp_ready && (sel == 2'd1);
    assign b0.rsp_ready = t_rsp_ready && (sel == 2'd2);
    assign b2.req_we = t_req_we;       assign b4.req_we = t_req_we;       assign b0.req_we = t_req_we;
    assign b2.req_addr = t_req_addr;   assign b4.req_addr = t_req_addr;   assign b0.req_addr = t_req_addr;
    assign b2.req_wdata = t_req_wdata; assign b4.req_wdata = t_req_wdata; assign b0.req_wdata = t_req_wdata;
    assign b2.req_be = t_req_be;       assign b4.req_be = t_req_be;       assign b0.req_be = t_req_be;

    always_comb begin
        c_req_ready = b2.req_ready;
        c_rsp_valid = b2.rsp_valid;
        c_rsp_err   = b2.rsp_err;
        c_rsp_rdata = b2.rsp_rdata;
        c_count     = b2.access_count;
        if (sel == 2'd1) begin
            c_req_ready = b4.req_ready;
            c_rsp_valid = b4.rsp_valid;
            c_rsp_err   = b4.rsp_err;
            c_rsp_rdata = b4.rsp_rdata;
            c_count     = b4.access_count;
        end else if (sel == 2'd2) begin
            c_req_ready = b0.req_ready;
            c_rsp_valid = b0.rsp_valid;
            c_rsp_err   = b0.rsp_err;
            c_rsp_rdata = b0.rsp_rdata;
            c_count     = b0.access_count;
        end
    end

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2), .BASE_ADDR(32'h0))
        u_dut2 (.clock(clock), .reset(rst2), .bus(b2));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(4), .BASE_ADDR(32'h0))
        u_dut4 (.clock(clock), .reset(rst4), .bus(b4));
    dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0), .BASE_ADDR(32'h100))
        u_dut0 (.clock(clock), .reset(rst0), .bus(b0));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s: got %h", nm, act);
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference memory for the sel 0 instance.
    logic [7:0] mdl_byte  [DEPTH2*4];
    bit         mdl_known [DEPTH2*4];

    function automatic void mdl_apply(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be,
                                      output logic [31:0] erd, output logic eerr,
                                      output bit rd_known);
        logic [31:0] off;
        int base;
        off      = addr - BASE2;
        eerr     = (addr % 4 != 0) || (off / 4 >= DEPTH2);
        erd      = 32'h0;
        rd_known = 1'b1;
        if (!eerr) begin
            base = int'(off);
            for (int b = 0; b < 4; b++) begin
                if (we) begin
                    if (be[b]) begin
                        mdl_byte[base+b]  = wdata[8*b +: 8];
                        mdl_known[base+b] = 1'b1;
                    end
                end else begin
                    erd[8*b +: 8] = mdl_byte[base+b];
                    if (!mdl_known[base+b]) rd_known = 1'b0;
                end
            end
        end
    endfunction

    // Full transaction on the selected instance. Entered just after a falling
    // edge; returns just after the falling edge following completion.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output logic stable);
        int n;
        stable = 1'b1;
        rdata  = '0;
        err    = 1'b0;
        lat    = 0;
        t_req_we = we; t_req_addr = addr; t_req_wdata = wdata; t_req_be = be;
        t_req_valid = 1'b1;
        n = 0;
        while (!c_req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!c_req_ready) begin
            chk("handshake_timeout", 32'd0, 32'd1);
            t_req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        // Scramble the request after acceptance; it must not matter.
        t_req_valid = 1'b0;
        t_req_we    = ~we;
        t_req_addr  = $urandom;
        t_req_wdata = $urandom;
        t_req_be    = 4'($urandom);
        lat = 1;
        while (!c_rsp_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        if (!c_rsp_valid) begin
            chk("response_timeout", 32'd0, 32'd1);
            return;
        end
        rdata = c_rsp_rdata;
        err   = c_rsp_err;
        if (c_req_ready) stable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            t_req_valid = 1'($urandom);
            @(negedge clock);
            if (!c_rsp_valid || c_rsp_rdata !== rdata || c_rsp_err !== err || c_req_ready)
                stable = 1'b0;
        end
        t_req_valid = 1'b0;
        t_rsp_ready = 1'b1;
        @(negedge clock);
        t_rsp_ready = 1'b0;
        if (c_rsp_valid || !c_req_ready) stable = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] rd, erd, addr;
        logic        er, eerr, st, we, saw_valid;
        logic [3:0]  be;
        bit          known;
        int          lat, r, hold;
        logic [15:0] exp_count;

        vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 5, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 0, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 1, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 0, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h22,       32'h0,        4'hF, 0, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'h0,        32'h0BADF00D, 4'hF, 0, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'h100,      32'hCAFEBABE, 4'hF, 2, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h0,        32'h0,        4'h0, 0, 32'h0BADF00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 0, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'h10,       32'h0,        4'h3, 0, 32'hDEADBEEF, 1'b0};
        vecs[11] = '{1'b1, 32'hFC,       32'h12345678, 4'hF, 0, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 32'hFC,       32'hA5A5A5A5, 4'hA, 0, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'hFC,       32'h0,        4'h0, 0, 32'hA534A578, 1'b0};
        vecs[14] = '{1'b1, 32'hFFFFFFFC, 32'h1,        4'hF, 0, 32'h0,        1'b1};
        vecs[15] = '{1'b0, 32'h13,       32'h0,        4'h0, 3, 32'h0,        1'b1};

        for (int i = 0; i < DEPTH2*4; i++) begin
            mdl_byte[i]  = 8'h0;
            mdl_known[i] = 1'b0;
        end

        sel = 2'd0;
        t_req_valid = 1'b0; t_req_we = 1'b0; t_rsp_ready = 1'b0;
        t_req_addr = '0; t_req_wdata = '0; t_req_be = '0;
        rst2 = 1'b1; rst4 = 1'b1; rst0 = 1'b1;
        repeat (3) @(negedge clock);
        rst2 = 1'b0; rst4 = 1'b0; rst0 = 1'b0;
        @(negedge clock);

        // Reset state
        chk("reset_req_ready", c_req_ready, 1);
        chk("reset_rsp_valid", c_rsp_valid, 0);
        chk("reset_rsp_rdata", c_rsp_rdata, 0);
        chk("reset_rsp_err",   c_rsp_err,   0);
        chk("reset_count",     c_count,     0);

        // Directed vector table on the WAIT_STATES=2 instance
        exp_count = 16'd0;
        for (int i = 0; i < 16; i++) begin
            mdl_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, erd, eerr, known);
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, rd, er, lat, st);
            exp_count++;
            chk($sformatf("vec%0d_rdata", i),   rd,      vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i),     er,      vecs[i].exp_err);
            chk($sformatf("vec%0d_latency", i), lat,     3);
            chk($sformatf("vec%0d_stable", i),  st,      1);
            chk($sformatf("vec%0d_count", i),   c_count, exp_count);
        end

        // Randomized traffic against the reference memory
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      addr = 32'(4 * $urandom_range(0, 15));
            else if (r < 7) addr = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            else if (r < 8) addr = 32'(4 * DEPTH2 + 4 * $urandom_range(0, 100));
            else if (r < 9) addr = 32'(4 * $urandom_range(48, 63));
            else            addr = $urandom;
            we   = 1'($urandom_range(0, 1));
            be   = 4'($urandom);
            hold = $urandom_range(0, 3);
            begin
                logic [31:0] wd;
                wd = $urandom;
                mdl_apply(we, addr, wd, be, erd, eerr, known);
                txn(we, addr, wd, be, hold, rd, er, lat, st);
            end
            exp_count++;
            chk($sformatf("rnd%0d_err", i), er, eerr);
            if (known) chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_latency", i), lat, 3);
            chk($sformatf("rnd%0d_stable", i), st, 1);
        end
        chk("rnd_count", c_count, exp_count);

        // Reset during WAIT on the WAIT_STATES=4 instance
        sel = 2'd1;
        @(negedge clock);
        txn(1'b1, 32'h40, 32'h00001111, 4'hF, 0, rd, er, lat, st);
        chk("ws4_store_latency", lat, 5);
        chk("ws4_count_before", c_count, 1);
        t_req_we = 1'b1; t_req_addr = 32'h40; t_req_wdata = 32'h55AA55AA; t_req_be = 4'hF;
        t_req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        t_req_valid = 1'b0;
        @(posedge clock);
        #1 chk("ws4_in_wait_ready", c_req_ready, 0);
        @(posedge clock);
        #2 rst4 = 1'b1;
        #1;
        chk("ws4_rst_req_ready", c_req_ready, 1);
        chk("ws4_rst_rsp_valid", c_rsp_valid, 0);
        chk("ws4_rst_rsp_rdata", c_rsp_rdata, 0);
        chk("ws4_rst_rsp_err",   c_rsp_err,   0);
        chk("ws4_rst_count",     c_count,     0);
        @(negedge clock);
        rst4 = 1'b0;
        saw_valid = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (c_rsp_valid) saw_valid = 1'b1;
        end
        chk("ws4_no_late_rsp", saw_valid, 0);
        txn(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat, st);
        chk("ws4_dropped_store_rdata", rd, 32'h00001111);
        txn(1'b1, 32'h40, 32'h0, 4'hF, 0, rd, er, lat, st);
        txn(1'b0, 32'h40, 32'h0, 4'h0, 1, rd, er, lat, st);
        chk("ws4_rewrite_rdata", rd, 32'h0);
        chk("ws4_rewrite_latency", lat, 5);
        chk("ws4_count_after", c_count, 3);

        // Back-to-back stream on the WAIT_STATES=0 instance
        sel = 2'd2;
        @(negedge clock);
        t_rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] exp_rd;
            logic        exp_er;
            chk($sformatf("bb%0d_req_ready", i), c_req_ready, 1);
            exp_rd = 32'h0;
            exp_er = 1'b0;
            if (i < 4) begin
                t_req_we = 1'b1; t_req_addr = 32'h100 + 32'(4*i); t_req_wdata = 32'hA0000000 + 32'(i);
            end else if (i < 8) begin
                t_req_we = 1'b0; t_req_addr = 32'h100 + 32'(4*(i-4)); t_req_wdata = 32'h0;
                exp_rd = 32'hA0000000 + 32'(i-4);
            end else if (i == 8) begin
                t_req_we = 1'b0; t_req_addr = 32'hFC; exp_er = 1'b1;
            end else begin
                t_req_we = 1'b1; t_req_addr = 32'h140; t_req_wdata = 32'hFFFFFFFF; exp_er = 1'b1;
            end
            t_req_be = 4'hF;
            t_req_valid = 1'b1;
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("bb%0d_rsp_valid", i), c_rsp_valid, 1);
            chk($sformatf("bb%0d_busy", i),      c_req_ready, 0);
            chk($sformatf("bb%0d_rdata", i),     c_rsp_rdata, exp_rd);
            chk($sformatf("bb%0d_err", i),       c_rsp_err,   exp_er);
            @(negedge clock);
        end
        t_req_valid = 1'b0;
        t_rsp_ready = 1'b0;
        chk("bb_count", c_count, 10);
        chk("bb_idle_rsp_valid", c_rsp_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
